ps2_key_decoder: RTL and testbench

//  - Upstream input stage of the Tetris core. Receives PS/2 keyboard frames and decodes make codes.
//  - Emits one-cycle keyboard_signal command pulses in the encoding that GameControl consumes:
//    000 idle, 100 down, 101 left, 110 right, 111 rotate.
//  - Break (release) codes are swallowed. Typematic repeats give one pulse per repeated make code.

---
 rtl/tetris_pkg.sv | 76 +++++++
 rtl/ps2_frame_rx.sv | 153 +++++++++++++++
 rtl/ps2_key_decoder.sv | 104 ++++++++++
 tb/tb_ps2_key_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tetris_pkg
//  Brief    : Shared constants, state encodings and scan-code map helpers
//             for the Tetris keyboard front end.
//  Revision : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    // Command encoding consumed by GameControl
    localparam logic [2:0] KEY_IDLE   = 3'b000;
    localparam logic [2:0] KEY_DOWN   = 3'b100;
    localparam logic [2:0] KEY_LEFT   = 3'b101;
    localparam logic [2:0] KEY_RIGHT  = 3'b110;
    localparam logic [2:0] KEY_ROTATE = 3'b111;

    // Prefix bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Base (letter) make codes
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;

    // Extended (arrow) make codes, valid only after SC_EXT
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;

    // Make/break decoder state
    typedef enum logic [1:0] {
        DEC_BASE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    // Frame receiver state
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Command for a non-prefixed make code; KEY_IDLE when unmapped
    function automatic logic [2:0] mapBaseCode(input logic [7:0] code);
        logic [2:0] key;
        case (code)
            SC_S:    key = KEY_DOWN;
            SC_A:    key = KEY_LEFT;
            SC_D:    key = KEY_RIGHT;
            SC_W:    key = KEY_ROTATE;
            default: key = KEY_IDLE;
        endcase
        return key;
    endfunction

    // Command for an E0-prefixed make code; KEY_IDLE when unmapped
    function automatic logic [2:0] mapExtCode(input logic [7:0] code);
        logic [2:0] key;
        case (code)
            SC_DOWN:  key = KEY_DOWN;
            SC_LEFT:  key = KEY_LEFT;
            SC_RIGHT: key = KEY_RIGHT;
            SC_UP:    key = KEY_ROTATE;
            default:  key = KEY_IDLE;
        endcase
        return key;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_frame_rx
//  Brief    : PS/2 device-to-host frame receiver. Synchronizes and deglitches
//             the raw PS/2 lines, shifts in 11-bit frames, checks odd parity
//             and the stop bit, and aborts stalled frames after a timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import tetris_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_error,
    output logic       frame_timeout
);

    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FILT_W-1:0] c_FILT_LAST    = FILT_W'(FILTER_LEN - 1);
    localparam logic [TMR_W-1:0]  c_TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_clkSync;
    logic [1:0]        r_dataSync;
    logic              r_filtLevel;
    logic [FILT_W-1:0] r_filtCnt;

    rx_state_t         r_state;
    logic [7:0]        r_shift;
    logic [2:0]        r_bitCnt;
    logic              r_parity;
    logic [TMR_W-1:0]  r_timer;
    logic [7:0]        r_byte;
    logic              r_byteValid;
    logic              r_byteError;
    logic              r_timeout;

    logic              w_clkSample;
    logic              w_data;
    logic              w_fall;

    assign w_clkSample = r_clkSync[1];
    assign w_data      = r_dataSync[1];

    // Falling edge fires in the very cycle the filtered level would drop to 0,
    // so the data bit is taken from the synchronizer in that same cycle.
    assign w_fall = r_filtLevel && !w_clkSample && (r_filtCnt == c_FILT_LAST);

    // Two-flop synchronizers; lines idle high so reset to 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk};
            r_dataSync <= {r_dataSync[0], ps2_data};
        end
    end

    // Glitch filter: toggle the filtered clock only after FILTER_LEN
    // consecutive samples that disagree with the current level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filtLevel <= 1'b1;
            r_filtCnt   <= '0;
        end else if (w_clkSample == r_filtLevel) begin
            r_filtCnt   <= '0;
        end else if (r_filtCnt == c_FILT_LAST) begin
            r_filtLevel <= w_clkSample;
            r_filtCnt   <= '0;
        end else begin
            r_filtCnt   <= r_filtCnt + 1'b1;
        end
    end

    // Frame receiver with stall timeout; status strobes are single-cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RX_IDLE;
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_parity    <= 1'b0;
            r_timer     <= '0;
            r_byte      <= '0;
            r_byteValid <= 1'b0;
            r_byteError <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_byteValid <= 1'b0;
            r_byteError <= 1'b0;
            r_timeout   <= 1'b0;
            if (r_state == RX_IDLE) begin
                r_timer <= '0;
                // A high data level on an idle edge is not a start bit
                if (w_fall && !w_data) begin
                    r_state  <= RX_DATA;
                    r_bitCnt <= '0;
                end
            end else if (w_fall) begin
                r_timer <= '0;
                case (r_state)
                    RX_DATA: begin
                        // LSB arrives first, so shift in from the top
                        r_shift  <= {w_data, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            r_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        r_parity <= w_data;
                        r_state  <= RX_STOP;
                    end
                    RX_STOP: begin
                        // Odd parity over data plus parity bit, and stop must be 1
                        if (w_data && (^{r_shift, r_parity})) begin
                            r_byte      <= r_shift;
                            r_byteValid <= 1'b1;
                        end else begin
                            r_byteError <= 1'b1;
                        end
                        r_state <= RX_IDLE;
                    end
                    default: begin
                        r_state <= RX_IDLE;
                    end
                endcase
            end else if (r_timer == c_TIMEOUT_LAST) begin
                // Keyboard stopped clocking mid-frame: drop the partial byte
                r_timeout <= 1'b1;
                r_timer   <= '0;
                r_state   <= RX_IDLE;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign rx_byte       = r_byte;
    assign byte_valid    = r_byteValid;
    assign byte_error    = r_byteError;
    assign frame_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_decoder
//  Brief    : Keyboard input stage for the Tetris core. Turns PS/2 make codes
//             into one-cycle game command pulses; break codes and unmapped
//             keys produce nothing.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import tetris_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] keyboard_signal,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_error
);

    logic [7:0] w_rxByte;
    logic       w_byteValid;
    logic       w_byteError;
    logic       w_frameTimeout;

    dec_state_t r_decState;
    logic [2:0] r_keySignal;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .rx_byte       (w_rxByte),
        .byte_valid    (w_byteValid),
        .byte_error    (w_byteError),
        .frame_timeout (w_frameTimeout)
    );

    // Make/break decoder and command pulse register; a timeout leaves the
    // decoder alone since no byte was lost, but a corrupt byte might have
    // been a prefix, so it drops back to BASE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_decState  <= DEC_BASE;
            r_keySignal <= KEY_IDLE;
        end else begin
            r_keySignal <= KEY_IDLE;
            if (w_byteError) begin
                r_decState <= DEC_BASE;
            end else if (w_byteValid) begin
                case (r_decState)
                    DEC_BASE: begin
                        if (w_rxByte == SC_EXT) begin
                            r_decState <= DEC_EXT;
                        end else if (w_rxByte == SC_BRK) begin
                            r_decState <= DEC_BRK;
                        end else begin
                            r_keySignal <= mapBaseCode(w_rxByte);
                        end
                    end
                    DEC_EXT: begin
                        if (w_rxByte == SC_EXT) begin
                            r_decState <= DEC_EXT;
                        end else if (w_rxByte == SC_BRK) begin
                            r_decState <= DEC_EXT_BRK;
                        end else begin
                            r_keySignal <= mapExtCode(w_rxByte);
                            r_decState  <= DEC_BASE;
                        end
                    end
                    DEC_BRK: begin
                        // Released key code is swallowed; E0 here starts a new extended sequence
                        if (w_rxByte == SC_EXT) begin
                            r_decState <= DEC_EXT;
                        end else begin
                            r_decState <= DEC_BASE;
                        end
                    end
                    DEC_EXT_BRK: begin
                        r_decState <= DEC_BASE;
                    end
                    default: begin
                        r_decState <= DEC_BASE;
                    end
                endcase
            end
        end
    end

    assign keyboard_signal = r_keySignal;
    assign scan_code       = w_rxByte;
    assign code_valid      = w_byteValid;
    assign frame_error     = w_byteError | w_frameTimeout;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Brief    : Directed bench for ps2_key_decoder with an event scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int         c_TIMEOUT = 2000;
    localparam logic [2:0] c_EV_CODE = 3'd1;
    localparam logic [2:0] c_EV_ERR  = 3'd2;
    localparam logic [2:0] c_EV_KEY  = 3'd3;
    localparam logic [2:0] c_EV_BAD  = 3'd4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2Clk   = 1'b1;
    logic       ps2Data  = 1'b1;
    logic [2:0] keyboardSignal;
    logic [7:0] scanCode;
    logic       codeValid;
    logic       frameError;

    logic [10:0] obsQ[$];
    logic [10:0] expQ[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic        prevCv      = 1'b0;

    ps2_key_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ps2_clk         (ps2Clk),
        .ps2_data        (ps2Data),
        .keyboard_signal (keyboardSignal),
        .scan_code       (scanCode),
        .code_valid      (codeValid),
        .frame_error     (frameError)
    );

    // 1 MHz system clock
    always #500 clk = ~clk;

    // Record DUT output events; a key pulse is legal only the cycle after code_valid
    always @(negedge clk) begin
        if (rst) begin
            prevCv <= 1'b0;
        end else begin
            if (codeValid && frameError) obsQ.push_back({c_EV_BAD, 8'hCE});
            if (codeValid)               obsQ.push_back({c_EV_CODE, scanCode});
            if (frameError)              obsQ.push_back({c_EV_ERR, scanCode});
            if (keyboardSignal != 3'b000) begin
                if (prevCv) obsQ.push_back({c_EV_KEY, 5'b0, keyboardSignal});
                else        obsQ.push_back({c_EV_BAD, 5'b0, keyboardSignal});
            end
            prevCv <= codeValid;
        end
    end

    function automatic logic [10:0] mkFrame(input logic [7:0] d, input logic badPar);
        return {1'b1, (~^d) ^ badPar, d, 1'b0};
    endfunction

    // One PS/2 bit: data changes mid-high, 40 us clock period
    task automatic ps2Bit(input logic b);
        #10000 ps2Data = b;
        #10000 ps2Clk  = 1'b0;
        #20000 ps2Clk  = 1'b1;
    endtask

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) ps2Bit(bits[i]);
        #10000 ps2Data = 1'b1;
    endtask

    task automatic expCode(input logic [7:0] c); expQ.push_back({c_EV_CODE, c}); endtask
    task automatic expErr(input logic [7:0] s);  expQ.push_back({c_EV_ERR, s});  endtask
    task automatic expKey(input logic [2:0] k);  expQ.push_back({c_EV_KEY, 5'b0, k}); endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop and compare all expected events against what the DUT produced
    task automatic drain(input string tag);
        int          waitCyc;
        logic [10:0] e;
        logic [10:0] o;
        waitCyc = 0;
        while (obsQ.size() < expQ.size() && waitCyc < 300) begin
            @(negedge clk);
            waitCyc++;
        end
        repeat (5) @(negedge clk);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (obsQ.size() > 0) o = obsQ.pop_front();
            else                 o = 11'h7FF;
            chk(tag, {21'b0, o}, {21'b0, e});
        end
        while (obsQ.size() > 0) begin
            o = obsQ.pop_front();
            chk({tag, "_extra"}, {21'b0, o}, 32'h0);
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic badPar);
        sendBits(mkFrame(d, badPar), 11);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_key",   {29'b0, keyboardSignal}, 32'h0);
        chk("rst_scan",  {24'b0, scanCode},       32'h0);
        chk("rst_valid", {31'b0, codeValid},      32'h0);
        chk("rst_err",   {31'b0, frameError},     32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 1: S -> down
        expCode(8'h1B); expKey(3'b100);
        frame(8'h1B, 1'b0);
        drain("t1_s");

        // 2: E0 6B -> left; E0 F0 6B -> nothing
        expCode(8'hE0); expCode(8'h6B); expKey(3'b101);
        frame(8'hE0, 1'b0); frame(8'h6B, 1'b0);
        drain("t2_left");
        expCode(8'hE0); expCode(8'hF0); expCode(8'h6B);
        frame(8'hE0, 1'b0); frame(8'hF0, 1'b0); frame(8'h6B, 1'b0);
        drain("t2_left_brk");

        // 3: F0 1C swallowed, then 1C -> left
        expCode(8'hF0); expCode(8'h1C);
        frame(8'hF0, 1'b0); frame(8'h1C, 1'b0);
        drain("t3_brk");
        expCode(8'h1C); expKey(3'b101);
        frame(8'h1C, 1'b0);
        drain("t3_a");

        // 4: bad parity keeps scan_code, resets prefix
        expErr(8'h1C);
        frame(8'h23, 1'b1);
        drain("t4_par");
        expCode(8'hE0); expErr(8'hE0); expCode(8'h74);
        frame(8'hE0, 1'b0); frame(8'h74, 1'b1); frame(8'h74, 1'b0);
        drain("t4_prefix");

        // 5: timeout aborts partial frame
        expErr(8'h74);
        sendBits(mkFrame(8'h1D, 1'b0), 5);
        #2500000;
        drain("t5_tmo");
        // timeout leaves a pending E0 prefix intact
        expCode(8'hE0); expErr(8'hE0); expCode(8'h75); expKey(3'b111);
        frame(8'hE0, 1'b0);
        sendBits(mkFrame(8'h75, 1'b0), 5);
        #2500000;
        frame(8'h75, 1'b0);
        drain("t5_tmo_ext");
        expCode(8'h1D); expKey(3'b111);
        frame(8'h1D, 1'b0);
        drain("t5_w");
        // short low glitch with data low must not start a frame
        @(negedge clk);
        ps2Data = 1'b0; ps2Clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2Clk = 1'b1; ps2Data = 1'b1;
        repeat (50) @(negedge clk);
        expCode(8'h1C); expKey(3'b101);
        frame(8'h1C, 1'b0);
        drain("t5_glitch");

        // 6: reset mid-frame discards the partial frame
        sendBits(mkFrame(8'h1D, 1'b0), 6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_key",   {29'b0, keyboardSignal}, 32'h0);
        chk("t6_rst_scan",  {24'b0, scanCode},       32'h0);
        chk("t6_rst_valid", {31'b0, codeValid},      32'h0);
        chk("t6_rst_err",   {31'b0, frameError},     32'h0);
        obsQ.delete();
        repeat (20) @(negedge clk);
        expCode(8'h1D); expKey(3'b111);
        frame(8'h1D, 1'b0);
        drain("t6_w");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
